// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types and saturating arithmetic helpers for the FNN neurons
package nn_pkg;

    typedef enum logic {
        ACT_IDENT = 1'b0,
        ACT_RELU  = 1'b1
    } act_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_FINAL,
        ST_OUT
    } state_e;

    localparam int SAT_MAXW = 64;
    localparam logic signed [SAT_MAXW-1:0] SAT_ONE = 1;

    function automatic int acc_width(input int data_w);
        return 2 * data_w;
    endfunction

    // Operands are sign-extended to SAT_MAXW; the result saturates to w bits.
    function automatic logic signed [SAT_MAXW-1:0] sat_add(
        input logic signed [SAT_MAXW-1:0] a,
        input logic signed [SAT_MAXW-1:0] b,
        input int w
    );
        logic signed [SAT_MAXW:0] s;
        logic signed [SAT_MAXW:0] mx;
        logic signed [SAT_MAXW:0] mn;
        s  = {a[SAT_MAXW-1], a} + {b[SAT_MAXW-1], b};
        mx = ((SAT_MAXW+1)'(SAT_ONE) <<< (w - 1)) - (SAT_MAXW+1)'(SAT_ONE);
        mn = ~mx;
        if (s > mx) begin
            return mx[SAT_MAXW-1:0];
        end
        if (s < mn) begin
            return mn[SAT_MAXW-1:0];
        end
        return s[SAT_MAXW-1:0];
    endfunction

    function automatic logic signed [SAT_MAXW-1:0] sat_clip(
        input logic signed [SAT_MAXW-1:0] a,
        input int w
    );
        logic signed [SAT_MAXW-1:0] mx;
        logic signed [SAT_MAXW-1:0] mn;
        mx = (SAT_ONE <<< (w - 1)) - SAT_ONE;
        mn = ~mx;
        if (a > mx) begin
            return mx;
        end
        if (a < mn) begin
            return mn;
        end
        return a;
    endfunction

endpackage

// File: rtl/neuron_wmem.sv
// rtl/neuron_wmem.sv - banked weight memory, one bank per lane, common synchronous read row
module neuron_wmem #(
    parameter int DATA_W = 16,
    parameter int LANES  = 2,
    parameter int BEATS  = 5,
    parameter int LW     = (LANES > 1) ? $clog2(LANES) : 1,
    parameter int BW     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                      clk,
    input  logic                      i_wr_en,
    input  logic [LW-1:0]             i_wr_bank,
    input  logic [BW-1:0]             i_wr_row,
    input  logic [DATA_W-1:0]         i_wr_data,
    input  logic                      i_rd_en,
    input  logic [BW-1:0]             i_rd_row,
    output logic [LANES*DATA_W-1:0]   o_rd_data
);

    for (genvar b = 0; b < LANES; b++) begin : g_bank
        logic [DATA_W-1:0] r_mem [BEATS];
        logic [DATA_W-1:0] r_q;

        always_ff @(posedge clk) begin
            if (i_wr_en && (i_wr_bank == LW'(b))) begin
                r_mem[i_wr_row] <= i_wr_data;
            end
            if (i_rd_en) begin
                r_q <= r_mem[i_rd_row];
            end
        end

        assign o_rd_data[b*DATA_W +: DATA_W] = r_q;
    end

endmodule

// File: rtl/neuron_par.sv
// rtl/neuron_par.sv - multi-lane saturating MAC neuron with loadable weights/bias and ReLU/identity output
module neuron_par
    import nn_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int INT_W      = 1,
    parameter int NUM_WEIGHT = 10,
    parameter int LANES      = 2,
    parameter int LAYER_ID   = 1,
    parameter int NEURON_ID  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             cfg_layer_num,
    input  logic [31:0]             cfg_neuron_num,
    input  logic                    weight_valid,
    input  logic [31:0]             weight_value,
    input  logic                    bias_valid,
    input  logic [31:0]             bias_value,
    input  logic                    act_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    load_err
);

    localparam int FRAC  = DATA_W - INT_W;
    localparam int BEATS = NUM_WEIGHT / LANES;
    localparam int ACC_W = acc_width(DATA_W);
    localparam int PW    = 2 * DATA_W;
    localparam int LSW   = PW + $clog2(LANES);
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    if ((NUM_WEIGHT % LANES) != 0) begin : g_bad_lanes
        $error("neuron_par: NUM_WEIGHT must be a multiple of LANES");
    end
    if (LSW > SAT_MAXW) begin : g_bad_width
        $error("neuron_par: DATA_W too wide for the saturation helpers");
    end

    state_e                    r_state;
    state_e                    w_next;
    logic                      w_in_ready;
    logic                      w_accept;
    logic                      w_out_hs;
    logic [BW-1:0]             r_cnt;
    act_e                      r_act;

    logic                      w_cfg_hit;
    logic                      w_wr_en;
    logic [LW-1:0]             r_wp_bank;
    logic [BW-1:0]             r_wp_row;
    logic signed [DATA_W-1:0]  r_bias;
    logic                      r_load_err;

    logic [LANES*DATA_W-1:0]   w_rd_data;
    logic [LANES*DATA_W-1:0]   r_x;
    logic                      r_s0_v;
    logic                      r_s1_v;
    logic signed [PW-1:0]      w_prod [LANES];
    logic signed [PW-1:0]      r_prod [LANES];
    logic signed [LSW-1:0]     w_lane_sum;
    logic signed [ACC_W-1:0]   r_acc;
    logic signed [ACC_W-1:0]   w_acc_next;

    logic signed [SAT_MAXW-1:0] w_biased;
    logic signed [SAT_MAXW-1:0] w_shift;
    logic signed [DATA_W-1:0]   w_clip;
    logic [DATA_W-1:0]          w_act_res;
    logic [DATA_W-1:0]          r_out;
    logic                       w_unused;

    assign w_unused  = &{1'b0, weight_value[31:DATA_W], bias_value[31:DATA_W]};

    assign w_accept  = in_valid && w_in_ready;
    assign w_out_hs  = (r_state == ST_OUT) && out_ready;
    assign w_cfg_hit = (cfg_layer_num == 32'(LAYER_ID)) && (cfg_neuron_num == 32'(NEURON_ID));
    assign w_wr_en   = weight_valid && w_cfg_hit && (r_state == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_next = (BEATS == 1) ? ST_DRAIN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_cnt == BW'(BEATS - 1))) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_s0_v && !r_s1_v) begin
                    w_next = ST_FINAL;
                end
            end
            ST_FINAL: w_next = ST_OUT;
            ST_OUT: begin
                if (out_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_cnt is the row of the beat being accepted; it sits at 0 outside a vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_act <= ACT_IDENT;
        end else if (w_accept) begin
            r_cnt <= (w_next == ST_DRAIN) ? '0 : r_cnt + 1'b1;
            if (r_state == ST_IDLE) begin
                r_act <= act_e'(act_sel);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp_bank  <= '0;
            r_wp_row   <= '0;
            r_bias     <= '0;
            r_load_err <= 1'b0;
        end else begin
            if (w_wr_en) begin
                if (r_wp_bank == LW'(LANES - 1)) begin
                    r_wp_bank <= '0;
                    r_wp_row  <= (r_wp_row == BW'(BEATS - 1)) ? '0 : r_wp_row + 1'b1;
                end else begin
                    r_wp_bank <= r_wp_bank + 1'b1;
                end
            end
            if (bias_valid && w_cfg_hit && (r_state == ST_IDLE)) begin
                r_bias <= bias_value[DATA_W-1:0];
            end
            if ((weight_valid || bias_valid) && w_cfg_hit && (r_state != ST_IDLE)) begin
                r_load_err <= 1'b1;
            end
        end
    end

    neuron_wmem #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .BEATS  (BEATS),
        .LW     (LW),
        .BW     (BW)
    ) u_wmem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_bank (r_wp_bank),
        .i_wr_row  (r_wp_row),
        .i_wr_data (weight_value[DATA_W-1:0]),
        .i_rd_en   (w_accept),
        .i_rd_row  (r_cnt),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        w_lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            w_prod[k]  = PW'($signed(r_x[k*DATA_W +: DATA_W])) *
                         PW'($signed(w_rd_data[k*DATA_W +: DATA_W]));
            w_lane_sum = w_lane_sum + LSW'(r_prod[k]);
        end
        w_acc_next = ACC_W'(sat_add(SAT_MAXW'(r_acc), SAT_MAXW'(w_lane_sum), ACC_W));
    end

    // Three stages: bank read + input capture, product, accumulate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s0_v <= 1'b0;
            r_s1_v <= 1'b0;
            r_x    <= '0;
            r_acc  <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_prod[k] <= '0;
            end
        end else begin
            r_s0_v <= w_accept;
            r_s1_v <= r_s0_v;
            if (w_accept) begin
                r_x <= in_data;
            end
            if (r_s0_v) begin
                for (int k = 0; k < LANES; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
            if (w_out_hs) begin
                r_acc <= '0;
            end else if (r_s1_v) begin
                r_acc <= w_acc_next;
            end
        end
    end

    always_comb begin
        w_biased  = sat_add(SAT_MAXW'(r_acc), SAT_MAXW'(r_bias) <<< FRAC, ACC_W);
        w_shift   = w_biased >>> FRAC;
        w_clip    = DATA_W'(sat_clip(w_shift, DATA_W));
        w_act_res = ((r_act == ACT_RELU) && w_clip[DATA_W-1]) ? '0 : w_clip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= '0;
        end else if (r_state == ST_FINAL) begin
            r_out <= w_act_res;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = (r_state == ST_OUT);
    assign out_data  = r_out;
    assign load_err  = r_load_err;

endmodule

// File: tb/tb_neuron_par.sv
// tb/tb_neuron_par.sv - directed table-driven bench for neuron_par (NUM_WEIGHT=4, LANES=2)
module tb_neuron_par;

    localparam int DW = 16;
    localparam int LN = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   cfg_layer_num = 32'd0;
    logic [31:0]   cfg_neuron_num = 32'd0;
    logic          weight_valid = 1'b0;
    logic [31:0]   weight_value = 32'd0;
    logic          bias_valid = 1'b0;
    logic [31:0]   bias_value = 32'd0;
    logic          act_sel = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [LN*DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          load_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    neuron_par #(
        .DATA_W     (16),
        .INT_W      (1),
        .NUM_WEIGHT (4),
        .LANES      (2),
        .LAYER_ID   (1),
        .NEURON_ID  (0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_layer_num  (cfg_layer_num),
        .cfg_neuron_num (cfg_neuron_num),
        .weight_valid   (weight_valid),
        .weight_value   (weight_value),
        .bias_valid     (bias_valid),
        .bias_value     (bias_value),
        .act_sel        (act_sel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .load_err       (load_err)
    );

    typedef struct packed {
        logic [3:0][15:0] w;
        logic [3:0][15:0] x;
        logic [15:0]      b;
        logic             act;
        logic [15:0]      exp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_weight(input logic [15:0] v, input logic [31:0] nid);
        cfg_layer_num  = 32'd1;
        cfg_neuron_num = nid;
        weight_value   = {16'hA5A5, v};
        weight_valid   = 1'b1;
        tick();
        weight_valid   = 1'b0;
    endtask

    task automatic wr_bias(input logic [15:0] v);
        cfg_layer_num  = 32'd1;
        cfg_neuron_num = 32'd0;
        bias_value     = {16'h5A5A, v};
        bias_valid     = 1'b1;
        tick();
        bias_valid     = 1'b0;
    endtask

    task automatic load(input logic [3:0][15:0] w, input logic [15:0] b);
        for (int i = 0; i < 4; i++) begin
            wr_weight(w[i], 32'd0);
        end
        wr_bias(b);
    endtask

    task automatic send_beat(input logic [31:0] data, input logic act, input string nm);
        int n;
        in_data  = data;
        act_sel  = act;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL %s accept: timeout got in_ready=0 required 1", nm);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    // act_sel is flipped on the second beat: only the first beat's value may count.
    task automatic send_vec(input logic [3:0][15:0] x, input logic act, input string nm);
        send_beat({x[1], x[0]}, act, nm);
        send_beat({x[3], x[2]}, ~act, nm);
    endtask

    task automatic finish_vec(input logic [15:0] exp, input string nm);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        chk({nm, " latency"}, n, 4);
        chk({nm, " data"}, out_data, exp);
        chk({nm, " in_ready"}, in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({nm, " done"}, out_valid, 0);
    endtask

    initial begin
        logic [3:0][15:0] w_q;
        logic [3:0][15:0] x_h;
        tbl[0] = '{w: {4{16'h2000}}, x: {4{16'h4000}}, b: 16'h1000, act: 1'b0, exp: 16'h5000};
        tbl[1] = '{w: {4{16'h4000}}, x: {4{16'h4000}}, b: 16'h7FFF, act: 1'b0, exp: 16'h7FFF};
        tbl[2] = '{w: {4{16'hC000}}, x: {4{16'h4000}}, b: 16'h0000, act: 1'b0, exp: 16'h8000};
        tbl[3] = '{w: {4{16'hC000}}, x: {4{16'h4000}}, b: 16'h0000, act: 1'b1, exp: 16'h0000};
        tbl[4] = '{w: {4{16'h8000}}, x: {4{16'h8000}}, b: 16'h0000, act: 1'b0, exp: 16'h7FFF};
        tbl[5] = '{w: {4{16'h8000}}, x: {4{16'h7FFF}}, b: 16'h0000, act: 1'b0, exp: 16'h8000};
        tbl[6] = '{w: {16'h0000, 16'h2000, 16'h0000, 16'h4000},
                   x: {16'h7FFF, 16'hC000, 16'h7FFF, 16'h2000},
                   b: 16'h0100, act: 1'b1, exp: 16'h0100};
        tbl[7] = '{w: {4{16'hFFFF}}, x: {4{16'h0001}}, b: 16'h0000, act: 1'b0, exp: 16'hFFFF};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("reset in_ready", in_ready, 1);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_data", out_data, 0);
        chk("reset load_err", load_err, 0);

        for (int i = 0; i < 8; i++) begin
            load(tbl[i].w, tbl[i].b);
            send_vec(tbl[i].x, tbl[i].act, $sformatf("vec%0d", i));
            finish_vec(tbl[i].exp, $sformatf("vec%0d", i));
        end

        // Result held against back-pressure while a new beat waits.
        w_q = {4{16'h2000}};
        x_h = {4{16'h4000}};
        load(w_q, 16'h1000);
        send_vec(x_h, 1'b0, "hold");
        begin
            int n;
            n = 0;
            while (!out_valid && n < 40) begin
                tick();
                n++;
            end
        end
        in_data  = {x_h[1], x_h[0]};
        act_sel  = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("hold valid c%0d", c), out_valid, 1);
            chk($sformatf("hold data c%0d", c), out_data, 16'h5000);
            chk($sformatf("hold in_ready c%0d", c), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold release valid", out_valid, 0);
        chk("hold release in_ready", in_ready, 1);
        send_beat({x_h[1], x_h[0]}, 1'b0, "hold b0");
        send_beat({x_h[3], x_h[2]}, 1'b1, "hold b1");
        finish_vec(16'h5000, "hold next");

        // Config writes while busy are dropped and flagged.
        send_beat({x_h[1], x_h[0]}, 1'b0, "err b0");
        wr_weight(16'h7FFF, 32'd0);
        wr_bias(16'h7FFF);
        chk("err load_err", load_err, 1);
        send_beat({x_h[3], x_h[2]}, 1'b0, "err b1");
        finish_vec(16'h5000, "err result");
        wr_weight(16'h7FFF, 32'd3);
        send_vec(x_h, 1'b0, "nomatch");
        finish_vec(16'h5000, "nomatch result");
        chk("err sticky", load_err, 1);

        // Reset mid-vector: bias and partial sum gone, weights kept.
        send_beat({x_h[1], x_h[0]}, 1'b0, "rst b0");
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick();
        chk("rst load_err", load_err, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        send_vec(x_h, 1'b0, "rst vec");
        finish_vec(16'h4000, "rst nobias");
        wr_bias(16'h1000);
        send_vec(x_h, 1'b0, "rst vec2");
        finish_vec(16'h5000, "rst bias");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
